// File: rtl/mips_pkg.sv
// Shared MIPS datapath types: default register-file geometry and the
// write-back request record used by the write-port arbiter.
package mips_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus between the datapath (pipeline WB, MDU, hazard unit, register file)
// and the register-file write-port arbiter.
interface regfile_wb_arbiter_if
  import mips_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                 wb_valid;
  logic [ADDR_W-1:0]    wb_addr;
  logic [DATA_W-1:0]    wb_data;
  logic                 mdu_valid;
  logic                 mdu_ready;
  logic [ADDR_W-1:0]    mdu_addr;
  logic [DATA_W-1:0]    mdu_data;
  logic                 rf_we;
  logic [ADDR_W-1:0]    rf_addr;
  logic [DATA_W-1:0]    rf_wdata;
  logic [2**ADDR_W-1:0] busy;
  logic                 stall_req;
  logic [CNT_W-1:0]     fifo_count;

  modport master (
    output wb_valid, wb_addr, wb_data, mdu_valid, mdu_addr, mdu_data,
    input  mdu_ready, rf_we, rf_addr, rf_wdata, busy, stall_req, fifo_count
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, mdu_valid, mdu_addr, mdu_data,
    output mdu_ready, rf_we, rf_addr, rf_wdata, busy, stall_req, fifo_count
  );
endinterface

// File: rtl/regfile_wb_fifo.sv
// MDU result FIFO: circular buffer with per-entry valid bits, an
// address-match squash port and a head-valid flag.
module regfile_wb_fifo #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [ADDR_W-1:0]             push_addr,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  input  logic                          squash,
  input  logic [ADDR_W-1:0]             squash_addr,
  output logic                          head_valid,
  output logic [ADDR_W-1:0]             head_addr,
  output logic [DATA_W-1:0]             head_data,
  output logic [CNT_W-1:0]              count,
  output logic [DEPTH-1:0]              ent_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]  ent_addr
);

  logic [DEPTH-1:0][ADDR_W-1:0] addr_mem;
  logic [DATA_W-1:0]            data_mem [DEPTH];
  logic [DEPTH-1:0]             vld;
  logic [PTR_W-1:0]             rd_ptr;
  logic [PTR_W-1:0]             wr_ptr;

  // Slots leave vld set only while occupied, so an empty FIFO reads head_valid=0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments; later ones in this block override earlier ones for the same bit.
      for (int i = 0; i < DEPTH; i++) begin
        if (squash && addr_mem[i] == squash_addr) vld[i] <= 1'b0;
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: payload storage is not reset; the valid bits alone say which slots mean anything.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  assign head_valid = vld[rd_ptr];
  assign head_addr  = addr_mem[rd_ptr];
  assign head_data  = data_mem[rd_ptr];
  assign ent_valid  = vld;
  assign ent_addr   = addr_mem;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline write-back beats queued MDU results.
// Optional starvation guard enabled by defining REGFILE_WB_ARB_STARVE_GUARD_EN.
module regfile_wb_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic           clk,
  input logic           rst_n,
  regfile_wb_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int NREG  = 2 ** ADDR_W;

  logic                         wb_win, push, pop, head_take, fifo_empty;
  logic                         head_valid;
  logic [ADDR_W-1:0]            head_addr;
  logic [DATA_W-1:0]            head_data;
  logic [CNT_W-1:0]             count;
  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic                         rf_we_q, out_mdu;
  logic [ADDR_W-1:0]            rf_addr_q;
  logic [DATA_W-1:0]            rf_wdata_q;
  logic [NREG-1:0]              busy_c;

  assign bus.mdu_ready = (count < CNT_W'(DEPTH));
  assign wb_win        = bus.wb_valid && (bus.wb_addr != '0);
  // A younger pipeline write to the same register makes the MDU result dead on arrival.
  assign push          = bus.mdu_valid && bus.mdu_ready && (bus.mdu_addr != '0) &&
                         !(wb_win && bus.wb_addr == bus.mdu_addr);
  assign fifo_empty    = (count == '0);
  assign head_take     = head_valid && !wb_win;
  assign pop           = !fifo_empty && (!head_valid || !wb_win);

  regfile_wb_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_addr  (bus.mdu_addr),
    .push_data  (bus.mdu_data),
    .pop        (pop),
    .squash     (wb_win),
    .squash_addr(bus.wb_addr),
    .head_valid (head_valid),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .count      (count),
    .ent_valid  (ent_valid),
    .ent_addr   (ent_addr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      out_mdu    <= 1'b0;
    end else begin
      rf_we_q <= wb_win || head_take;
      out_mdu <= head_take;
      if (wb_win) begin
        rf_addr_q  <= bus.wb_addr;
        rf_wdata_q <= bus.wb_data;
      end else if (head_take) begin
        rf_addr_q  <= head_addr;
        rf_wdata_q <= head_data;
      end
    end
  end

  assign bus.rf_we      = rf_we_q;
  assign bus.rf_addr    = rf_addr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.fifo_count = count;

  always_comb begin
    // NOTE: default first so every path assigns busy_c and no latch is inferred.
    busy_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) busy_c[ent_addr[i]] = 1'b1;
    end
    if (out_mdu) busy_c[rf_addr_q]    = 1'b1;
    if (push)    busy_c[bus.mdu_addr] = 1'b1;
    busy_c[0] = 1'b0;
  end

  assign bus.busy = busy_c;

`ifdef REGFILE_WB_ARB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic [SC_W-1:0] starve_cnt;
  logic            stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else begin
      if (head_take || fifo_empty)
        starve_cnt <= '0;
      else if (head_valid && wb_win && starve_cnt != SC_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + SC_W'(1);
      stall_q <= (starve_cnt == SC_W'(STARVE_LIMIT)) && !head_take;
    end
  end

  assign bus.stall_req = stall_q;
`else
  assign bus.stall_req = 1'b0;
`endif

endmodule
